// File: rtl/fifo_read_scheduler.sv
// Round-robin burst read scheduler for CH_NUM dual-clock FIFOs on their shared read clock.
// Read data is merged into one valid/ready stream tagged with its source channel.
module fifo_read_scheduler #(
    parameter  int CH_NUM  = 4,
    parameter  int M_WIDTH = 32,
    parameter  int BURST   = 16,
    localparam int CH_W    = $clog2(CH_NUM)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic [CH_NUM-1:0]         i_ch_mask,
    input  logic [CH_NUM-1:0]         i_empty,
    output logic [CH_NUM-1:0]         o_read_enable,
    input  logic [CH_NUM*M_WIDTH-1:0] i_read_data,
    input  logic [CH_NUM-1:0]         i_read_data_valid,
    output logic [M_WIDTH-1:0]        o_data,
    output logic [CH_W-1:0]           o_chan,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [CH_W-1:0]           o_grant,
    output logic                      o_busy
);
    localparam logic [7:0] BURST_L = 8'(BURST);

    typedef enum logic {S_IDLE, S_READ} state_t;

    typedef struct packed {
        logic [CH_W-1:0]    chan;
        logic [M_WIDTH-1:0] data;
    } entry_t;

    state_t          state_q;
    logic [CH_W-1:0] grant_q;
    logic [7:0]      burst_q;
    logic            inflight_q;
    logic [CH_W-1:0] issue_ch_q;
    entry_t          buf_q [2];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      occ_q;

    logic            found;
    logic [CH_W-1:0] next_ch;
    logic [CH_W-1:0] cand;
    logic            pop;
    logic            push;
    logic [2:0]      credit_sum;
    logic            credit_ok;
    logic            rd_ok;
    logic            issue;
    entry_t          head;

    // Rotating search starting just after the last granted channel.
    always_comb begin
        found   = 1'b0;
        next_ch = grant_q;
        cand    = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            if (int'(grant_q) + i >= CH_NUM) cand = CH_W'(int'(grant_q) + i - CH_NUM);
            else                             cand = CH_W'(int'(grant_q) + i);
            if (!found && i_ch_mask[cand] && !i_empty[cand]) begin
                found   = 1'b1;
                next_ch = cand;
            end
        end
    end

    assign pop  = o_valid && i_ready;
    assign push = inflight_q && i_read_data_valid[issue_ch_q];

    // Words already buffered plus the one in flight must leave room for the next.
    assign credit_sum = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign credit_ok  = credit_sum < 3'd2;

    assign rd_ok = i_enable && i_ch_mask[grant_q] && !i_empty[grant_q];
    assign issue = (state_q == S_READ) && rd_ok && credit_ok;

    assign o_read_enable = issue ? ({{(CH_NUM-1){1'b0}}, 1'b1} << grant_q) : '0;

    assign head    = buf_q[rd_ptr_q];
    assign o_data  = head.data;
    assign o_chan  = head.chan;
    assign o_valid = occ_q != 2'd0;
    assign o_grant = grant_q;
    assign o_busy  = (state_q != S_IDLE) || inflight_q || (occ_q != 2'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= CH_W'(CH_NUM - 1);
            burst_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_enable && found) begin
                        grant_q <= next_ch;
                        burst_q <= '0;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (!rd_ok) begin
                        state_q <= S_IDLE;
                    end else if (issue) begin
                        burst_q <= burst_q + 8'd1;
                        if (burst_q + 8'd1 == BURST_L) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // A read that returns without valid (stale empty flag) is simply not pushed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 2; k++) buf_q[k] <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            issue_ch_q <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) issue_ch_q <= grant_q;
            if (push) begin
                buf_q[wr_ptr_q] <= '{chan: issue_ch_q,
                                     data: i_read_data[issue_ch_q*M_WIDTH +: M_WIDTH]};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Directed bench for fifo_read_scheduler with behavioural FIFOs whose empty flag lags one cycle.
module tb_fifo_read_scheduler;
    localparam int CH = 4;
    localparam int W  = 32;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_enable = 1'b1;
    logic [CH-1:0]     i_ch_mask = '1;
    logic [CH-1:0]     empty_r = '1;
    logic [CH-1:0]     o_read_enable;
    logic [CH*W-1:0]   rdata = '0;
    logic [CH-1:0]     rdv = '0;
    logic [W-1:0]      o_data;
    logic [CW-1:0]     o_chan;
    logic              o_valid;
    logic              i_ready = 1'b1;
    logic [CW-1:0]     o_grant;
    logic              o_busy;

    int checks = 0;
    int errors = 0;

    fifo_read_scheduler #(.CH_NUM(CH), .M_WIDTH(W), .BURST(16)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_ch_mask(i_ch_mask),
        .i_empty(empty_r), .o_read_enable(o_read_enable), .i_read_data(rdata),
        .i_read_data_valid(rdv), .o_data(o_data), .o_chan(o_chan), .o_valid(o_valid),
        .i_ready(i_ready), .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Behavioural source FIFOs: one-cycle read latency, empty flag one cycle stale.
    logic [W-1:0] fmem [CH][64];
    int fhead [CH] = '{default: 0};
    int ftail [CH] = '{default: 0};
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < CH; k++) begin
            if (o_read_enable[k] && fhead[k] != ftail[k]) begin
                rdata[k*W +: W] <= fmem[k][fhead[k] % 64];
                rdv[k]          <= 1'b1;
                fhead[k]        <= fhead[k] + 1;
            end else begin
                rdv[k] <= 1'b0;
            end
            empty_r[k] <= (fhead[k] == ftail[k]);
        end
    end

    // Output capture plus continuous protocol observation.
    logic [CW+W-1:0] outq [$];
    int outcyc [$];
    int occ_tb = 0;
    int viol = 0;
    logic [CH-1:0] pren_m = '0;

    always @(negedge clk) begin
        if (!i_rst_n) begin
            occ_tb = 0;
            pren_m = '0;
        end else begin
            if (occ_tb > 2) viol++;
            if (o_valid !== (occ_tb != 0)) viol++;
            if ($countones(o_read_enable) > 1) viol++;
            if ((o_read_enable & ~i_ch_mask) != '0) viol++;
            if (o_read_enable != '0 &&
                occ_tb + int'(pren_m != '0) - int'(o_valid && i_ready) >= 2) viol++;
            if (|rdv) occ_tb++;
            if (o_valid && i_ready) begin
                outq.push_back({o_chan, o_data});
                outcyc.push_back(cyc);
                occ_tb--;
            end
            pren_m = o_read_enable;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic load(input int ch, input int base, input int n);
        for (int i = 0; i < n; i++) fmem[ch][(ftail[ch] + i) % 64] = W'(base + i);
        ftail[ch] = ftail[ch] + n;
    endtask

    task automatic wait_outs(input int ob, input int n, input int budget, output bit ok);
        int c = 0;
        while (outq.size() - ob < n && c < budget) begin
            tick();
            c++;
        end
        ok = (outq.size() - ob >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int c = 0;
        int quiet = 0;
        while (quiet < 3 && c < budget) begin
            tick();
            c++;
            if (!o_busy && empty_r == '1 && fhead == ftail) quiet++;
            else quiet = 0;
        end
        ok = (quiet >= 3);
    endtask

    task automatic test_reset();
        tick();
        checks++; if (o_read_enable !== '0) begin errors++; $display("FAIL reset_ren: got %h expected 0", o_read_enable); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_data); end
        checks++; if (o_chan !== '0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", o_chan); end
        checks++; if (o_grant !== CW'(CH - 1)) begin errors++; $display("FAIL reset_grant: got %0d expected %0d", o_grant, CH - 1); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_single();
        int ob;
        bit ok;
        logic [CW+W-1:0] e;
        do_reset();
        ob = outq.size();
        load(0, 'h10, 5);
        wait_outs(ob, 5, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d words expected 5", outq.size() - ob); end
        for (int i = 0; i < 5 && ob + i < outq.size(); i++) begin
            e = {CW'(0), W'('h10 + i)};
            checks++; if (outq[ob+i] !== e) begin errors++; $display("FAIL single_word%0d: got %h expected %h", i, outq[ob+i], e); end
            checks++; if (outcyc[ob+i] !== outcyc[ob] + i) begin errors++; $display("FAIL single_cycle%0d: got %0d expected %0d", i, outcyc[ob+i], outcyc[ob] + i); end
        end
        wait_idle(100, ok);
        checks++; if (!ok || o_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b expected 0", o_busy); end
        checks++; if (outq.size() - ob !== 5) begin errors++; $display("FAIL single_count: got %0d expected 5", outq.size() - ob); end
    endtask

    task automatic test_round_robin();
        int ob;
        bit ok;
        logic [CW+W-1:0] exp_q [$];
        do_reset();
        ob = outq.size();
        for (int i = 0; i < 16; i++) exp_q.push_back({CW'(0), W'('h100 + i)});
        for (int i = 0; i < 16; i++) exp_q.push_back({CW'(1), W'('h200 + i)});
        for (int i = 16; i < 20; i++) exp_q.push_back({CW'(0), W'('h100 + i)});
        for (int i = 16; i < 20; i++) exp_q.push_back({CW'(1), W'('h200 + i)});
        load(0, 'h100, 20);
        load(1, 'h200, 20);
        wait_outs(ob, 40, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d words expected 40", outq.size() - ob); end
        for (int i = 0; i < 40 && ob + i < outq.size(); i++) begin
            checks++; if (outq[ob+i] !== exp_q[i]) begin errors++; $display("FAIL rr_word%0d: got %h expected %h", i, outq[ob+i], exp_q[i]); end
        end
        wait_idle(200, ok);
        checks++; if (!ok || outq.size() - ob !== 40) begin errors++; $display("FAIL rr_count: got %0d expected 40", outq.size() - ob); end
    endtask

    task automatic test_backpressure();
        int ob;
        int v0;
        int c = 0;
        bit ok;
        logic [CW+W-1:0] e;
        logic [3:0] pat;
        pat = 4'b1001;
        do_reset();
        ob = outq.size();
        v0 = viol;
        load(2, 'h300, 8);
        while (outq.size() - ob < 8 && c < 200) begin
            i_ready = pat[3 - (c % 4)];
            tick();
            c++;
        end
        i_ready = 1'b1;
        wait_idle(100, ok);
        checks++; if (!ok || outq.size() - ob !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", outq.size() - ob); end
        for (int i = 0; i < 8 && ob + i < outq.size(); i++) begin
            e = {CW'(2), W'('h300 + i)};
            checks++; if (outq[ob+i] !== e) begin errors++; $display("FAIL bp_word%0d: got %h expected %h", i, outq[ob+i], e); end
        end
        checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL bp_protocol: got %0d violations expected 0", viol - v0); end
    endtask

    task automatic test_empty_mid();
        int ob;
        bit ok;
        logic [CW+W-1:0] exp_q [$];
        do_reset();
        ob = outq.size();
        for (int i = 0; i < 3; i++) exp_q.push_back({CW'(0), W'('h40 + i)});
        for (int i = 0; i < 2; i++) exp_q.push_back({CW'(3), W'('h70 + i)});
        load(0, 'h40, 3);
        load(3, 'h70, 2);
        wait_idle(200, ok);
        checks++; if (!ok || outq.size() - ob !== 5) begin errors++; $display("FAIL em_count: got %0d expected 5", outq.size() - ob); end
        for (int i = 0; i < 5 && ob + i < outq.size(); i++) begin
            checks++; if (outq[ob+i] !== exp_q[i]) begin errors++; $display("FAIL em_word%0d: got %h expected %h", i, outq[ob+i], exp_q[i]); end
        end
        checks++; if (o_grant !== CW'(3)) begin errors++; $display("FAIL em_grant: got %0d expected 3", o_grant); end
    endtask

    task automatic test_mask_enable();
        int ob;
        int v0;
        int c;
        bit ok;
        logic [CW+W-1:0] exp_q [$];
        do_reset();
        ob = outq.size();
        v0 = viol;
        i_ch_mask = 4'b1010;
        for (int k = 0; k < CH; k++) load(k, 'h500 + k * 16, 3);
        for (int i = 0; i < 3; i++) exp_q.push_back({CW'(1), W'('h510 + i)});
        for (int i = 0; i < 3; i++) exp_q.push_back({CW'(3), W'('h530 + i)});
        wait_outs(ob, 6, 100, ok);
        repeat (10) tick();
        checks++; if (outq.size() - ob !== 6) begin errors++; $display("FAIL mask_count: got %0d expected 6", outq.size() - ob); end
        for (int i = 0; i < 6 && ob + i < outq.size(); i++) begin
            checks++; if (outq[ob+i] !== exp_q[i]) begin errors++; $display("FAIL mask_word%0d: got %h expected %h", i, outq[ob+i], exp_q[i]); end
        end
        checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL mask_protocol: got %0d violations expected 0", viol - v0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mask_idle: got busy %b expected 0", o_busy); end

        ob = outq.size();
        i_ch_mask = '1;
        c = 0;
        while (!o_read_enable[0] && c < 20) begin
            tick();
            c++;
        end
        checks++; if (o_read_enable !== 4'b0001) begin errors++; $display("FAIL en_first_read: got %b expected 0001", o_read_enable); end
        tick();
        i_enable = 1'b0;
        #1;
        checks++; if (o_read_enable !== '0) begin errors++; $display("FAIL en_stop: got %b expected 0000", o_read_enable); end
        repeat (5) tick();
        checks++; if (outq.size() - ob !== 1 || outq[ob] !== {CW'(0), W'('h500)}) begin
            errors++; $display("FAIL en_inflight: got %0d words expected one word 0500 on ch0", outq.size() - ob);
        end
        checks++; if (o_busy !== 1'b0 || o_grant !== CW'(0)) begin errors++; $display("FAIL en_idle: got busy %b grant %0d expected 0 0", o_busy, o_grant); end

        ob = outq.size();
        i_enable = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back({CW'(2), W'('h520 + i)});
        for (int i = 1; i < 3; i++) exp_q.push_back({CW'(0), W'('h500 + i)});
        wait_idle(200, ok);
        checks++; if (!ok || outq.size() - ob !== 5) begin errors++; $display("FAIL en_resume_count: got %0d expected 5", outq.size() - ob); end
        for (int i = 0; i < 5 && ob + i < outq.size(); i++) begin
            checks++; if (outq[ob+i] !== exp_q[i]) begin errors++; $display("FAIL en_resume_word%0d: got %h expected %h", i, outq[ob+i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        bit hit = 1'b0;
        bit ok;
        logic [CH-1:0] pr;
        do_reset();
        load(1, 'h600, 6);
        load(3, 'h700, 2);
        while (!hit && c < 50) begin
            pr = o_read_enable;
            tick();
            c++;
            hit = o_valid && (pr != '0);
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_mid_setup: got no valid+inflight cycle expected one"); end
        i_rst_n = 1'b0;
        #1;
        checks++; if ({o_valid, o_busy, o_read_enable, o_chan, o_data} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: got valid %b busy %b ren %b chan %0d data %h expected all 0", o_valid, o_busy, o_read_enable, o_chan, o_data);
        end
        checks++; if (o_grant !== CW'(CH - 1)) begin errors++; $display("FAIL rst_mid_grant: got %0d expected %0d", o_grant, CH - 1); end
        repeat (2) tick();
        i_rst_n = 1'b1;
        c = 0;
        while (o_read_enable == '0 && c < 20) begin
            tick();
            c++;
        end
        checks++; if (o_read_enable !== 4'b0010 || o_grant !== CW'(1)) begin
            errors++; $display("FAIL rst_mid_first_grant: got ren %b grant %0d expected 0010 1", o_read_enable, o_grant);
        end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_drain: got busy %b expected drain to idle", o_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_empty_mid();
        test_mask_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
